cb_tag_allocator: RTL



---
 rtl/cb_tag_allocator_pkg.sv | 27 ++
 rtl/cb_tag_allocator_if.sv | 34 +++
 rtl/cb_tag_allocator_head_timer.sv | 78 +++++++
 rtl/cb_tag_allocator.sv | 99 +++++++++
 4 files changed

// File: rtl/cb_tag_allocator_pkg.sv
// Shared sizing for the completion-buffer tag allocator.
// Holds the buffer depth, the head-timeout limit and the derived
// tag, pointer, count and timer types used by the allocator and its head timer.
package cb_tag_allocator_pkg;

    localparam int unsigned log2size = 3;
    localparam int unsigned size     = 8;
    localparam int unsigned w_din    = 32;
    localparam int unsigned to_cyc   = 255;
    localparam int unsigned w_to     = 8;

    // tag: slot index; ptr: slot index plus lap bit; cnt: 0..size
    typedef logic [log2size-1:0] tag_t;
    typedef logic [log2size:0]   ptr_t;
    typedef logic [log2size:0]   cnt_t;
    typedef logic [w_to-1:0]     to_t;

    localparam cnt_t size_cnt    = cnt_t'(size);
    localparam to_t  to_sat      = to_t'(to_cyc);
    localparam to_t  to_last     = to_t'(to_cyc - 1);

    // Slot index part of a lap-extended pointer
    function automatic tag_t ptr_tag(input ptr_t p);
        return p[log2size-1:0];
    endfunction

endpackage

// File: rtl/cb_tag_allocator_if.sv
// Requester / completion / error bundle of the tag allocator.
//   req_v, req_rdy, req_tag, req_gen : tag request handshake
//   cpl_v                             : in-order retire from the completion buffer
//   oldest_tag, out_cnt               : outstanding-list status
//   timeout_err, timeout_tag, underflow_err, err_clr : sticky error reporting
// master = requester/system side, slave = the allocator.
interface cb_tag_allocator_if;
    import cb_tag_allocator_pkg::*;

    logic req_v;
    logic req_rdy;
    tag_t req_tag;
    logic req_gen;
    logic cpl_v;
    tag_t oldest_tag;
    cnt_t out_cnt;
    logic timeout_err;
    tag_t timeout_tag;
    logic underflow_err;
    logic err_clr;

    modport master (
        output req_v, cpl_v, err_clr,
        input  req_rdy, req_tag, req_gen, oldest_tag, out_cnt,
               timeout_err, timeout_tag, underflow_err
    );

    modport slave (
        input  req_v, cpl_v, err_clr,
        output req_rdy, req_tag, req_gen, oldest_tag, out_cnt,
               timeout_err, timeout_tag, underflow_err
    );

endinterface

// File: rtl/cb_tag_allocator_head_timer.sv
// Watches how long the oldest outstanding tag has been waiting.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   busy        : at least one tag outstanding
//   retire      : head tag retires this cycle
//   head_tag    : current oldest tag
//   err_clr     : clear timeout_err / timeout_tag
//   timeout_err : sticky, head waited to_cyc cycles
//   timeout_tag : head tag captured when timeout_err set
module cb_tag_allocator_head_timer
    import cb_tag_allocator_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic retire,
    input  tag_t head_tag,
    input  logic err_clr,
    output logic timeout_err,
    output tag_t timeout_tag
);

    to_t  to_cnt_r;
    logic timeout_err_r;
    tag_t timeout_tag_r;
    logic advance_s;
    logic to_set_s;

    // The counter advances only while the same head keeps waiting; the
    // error fires on the step that would reach the limit.
    always_comb begin
        advance_s = busy & ~retire;
        if (advance_s && (to_cnt_r == to_last)) begin
            to_set_s = 1'b1;
        end else begin
            to_set_s = 1'b0;
        end
    end

    // Head wait counter, saturating so it cannot retrigger without a new head
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_r <= '0;
        end else if (!advance_s) begin
            to_cnt_r <= '0;
        end else if (to_cnt_r != to_sat) begin
            to_cnt_r <= to_cnt_r + to_t'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Sticky timeout flag and tag; a new set beats a simultaneous clear,
    // and the first captured tag survives until it is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err_r <= 1'b0;
            timeout_tag_r <= '0;
        end else if (to_set_s) begin
            timeout_err_r <= 1'b1;
            if (!timeout_err_r || err_clr) begin
                timeout_tag_r <= head_tag;
            end else begin
                timeout_tag_r <= timeout_tag_r;
            end
        end else if (err_clr) begin
            timeout_err_r <= 1'b0;
            timeout_tag_r <= '0;
        end else begin
            timeout_err_r <= timeout_err_r;
            timeout_tag_r <= timeout_tag_r;
        end
    end

    assign timeout_err = timeout_err_r;
    assign timeout_tag = timeout_tag_r;

endmodule

// File: rtl/cb_tag_allocator.sv
// Hands out completion-buffer slot tags in allocation order and frees them
// in order as the buffer retires entries. Reports outstanding count, the
// expected present-bit polarity of the granted slot, the head tag, and
// sticky underflow / head-timeout errors.
// Ports:
//   clk, rst : clock, synchronous active-high reset (drops req_rdy while high)
//   bus      : cb_tag_allocator_if.slave (request, completion, status, errors)
module cb_tag_allocator
    import cb_tag_allocator_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    cb_tag_allocator_if.slave    bus
);

    ptr_t alloc_ptr_r;
    ptr_t retire_ptr_r;
    logic underflow_err_r;

    cnt_t out_cnt_s;
    logic busy_s;
    logic req_rdy_s;
    logic grant_s;
    logic retire_s;
    logic uf_set_s;
    logic timeout_err_s;
    tag_t timeout_tag_s;

    // Occupancy and handshake decode; req_rdy looks only at registered
    // occupancy, so a retire does not free a slot until the next cycle.
    always_comb begin
        out_cnt_s = alloc_ptr_r - retire_ptr_r;
        busy_s    = (out_cnt_s != cnt_t'(0));
        if (rst || (out_cnt_s == size_cnt)) begin
            req_rdy_s = 1'b0;
        end else begin
            req_rdy_s = 1'b1;
        end
        grant_s  = bus.req_v & req_rdy_s;
        retire_s = bus.cpl_v & busy_s;
        uf_set_s = bus.cpl_v & ~busy_s;
    end

    // Allocation pointer; the MSB is the lap bit
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr_r <= '0;
        end else if (grant_s) begin
            alloc_ptr_r <= alloc_ptr_r + ptr_t'(1);
        end else begin
            alloc_ptr_r <= alloc_ptr_r;
        end
    end

    // Retire pointer; a completion with nothing outstanding is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_ptr_r <= '0;
        end else if (retire_s) begin
            retire_ptr_r <= retire_ptr_r + ptr_t'(1);
        end else begin
            retire_ptr_r <= retire_ptr_r;
        end
    end

    // Sticky underflow flag; set beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_err_r <= 1'b0;
        end else if (uf_set_s) begin
            underflow_err_r <= 1'b1;
        end else if (bus.err_clr) begin
            underflow_err_r <= 1'b0;
        end else begin
            underflow_err_r <= underflow_err_r;
        end
    end

    cb_tag_allocator_head_timer u_head_timer (
        .clk         (clk),
        .rst         (rst),
        .busy        (busy_s),
        .retire      (retire_s),
        .head_tag    (ptr_tag(retire_ptr_r)),
        .err_clr     (bus.err_clr),
        .timeout_err (timeout_err_s),
        .timeout_tag (timeout_tag_s)
    );

    assign bus.req_rdy       = req_rdy_s;
    assign bus.req_tag       = ptr_tag(alloc_ptr_r);
    assign bus.req_gen       = ~alloc_ptr_r[log2size];
    assign bus.oldest_tag    = ptr_tag(retire_ptr_r);
    assign bus.out_cnt       = out_cnt_s;
    assign bus.timeout_err   = timeout_err_s;
    assign bus.timeout_tag   = timeout_tag_s;
    assign bus.underflow_err = underflow_err_r;

endmodule
